sync_updown_counter: RTL and testbench
======================================

Name: sync_updown_counter

Overview:
- Synchronous binary up/down counter with synchronous clear, parallel load, enable and a wrap-around (overflow) flag.
- It is the generic counting primitive used by the RPC DRAM controller timers (refresh/ZQC interval timers).
- A timer typically counts up to a ceiling, loads (freezes) a value during its output handshake, and clears to restart.
- The step is always 1; the count is modulo 2^WIDTH.

Parameters:
- WIDTH, 4, bit width of the count value q_o and the load value d_i; legal range 1..64.
- STICKY_OVERFLOW, 1'b0, 0 = overflow_o reflects only the most recent count step; 1 = overflow_o stays set once a wrap occurs, until clear or load.

Ports:
- clk_i  input  1  clock, rising-edge active.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous clear of count and overflow flag.
- en_i  input  1  count enable; one step per cycle while high.
- load_i  input  1  synchronous parallel load of d_i.
- down_i  input  1  direction: 0 = increment, 1 = decrement.
- d_i  input  WIDTH  value loaded when load_i is high.
- q_o  output  WIDTH  current count (registered).
- overflow_o  output  1  wrap flag (registered).

Behaviour:
- Reset: rst_ni low immediately forces q_o = 0 and the overflow flag = 0, independent of clk_i. Reset asserted mid-count aborts the count with no further side effects. The first update after release occurs on the first rising edge with rst_ni high.
- All non-reset updates happen on the rising clk_i edge. The effect is visible on q_o/overflow_o one cycle later; there is no combinational path from inputs to outputs.
- Priority per cycle: clear_i > load_i > en_i > hold.
- clear_i = 1:
  - q <= 0 and flag <= 0, regardless of load_i, en_i, down_i and d_i.
- load_i = 1 (clear_i = 0):
  - q <= d_i and flag <= 0. en_i and down_i are ignored that cycle.
- en_i = 1 (clear_i = 0, load_i = 0), up (down_i = 0):
  - q <= q + 1 mod 2^WIDTH.
  - The step wraps when q == 2^WIDTH-1, giving q <= 0.
- en_i = 1 (clear_i = 0, load_i = 0), down (down_i = 1):
  - q <= q - 1 mod 2^WIDTH.
  - The step wraps when q == 0, giving q <= 2^WIDTH-1.
- Overflow flag, STICKY_OVERFLOW = 0:
  - On every enabled step, flag <= 1 if that step wrapped, else 0.
  - Flag therefore reads 1 for exactly the cycles following a wrapping step, until the next enabled step, clear or load.
- Overflow flag, STICKY_OVERFLOW = 1:
  - Flag <= 1 on any wrapping step.
  - Otherwise it holds its value through non-wrapping steps and idle cycles.
  - Only clear_i, load_i or reset return it to 0.
- Hold (clear_i = load_i = en_i = 0): q and flag keep their values. down_i and d_i are don't-care.
- Loading 2^WIDTH-1 then stepping up wraps in the following enabled cycle.
- Direction may change on any cycle; each enabled step uses the down_i sampled in that cycle.
- No illegal input combinations exist. All simultaneous assertions resolve via the priority order above.
- Fully synchronous apart from the reset; no X propagation from unused inputs (d_i is ignored unless a load is accepted).

Test Plan:
- Reset/clear: WIDTH=4, count to 5, assert rst_ni low → q_o=0, overflow_o=0 immediately. Release, count to 3, pulse clear_i together with en_i and load_i (d_i=9) → q_o=0 next cycle.
- Up wrap, non-sticky: WIDTH=4, en_i=1, down_i=0 from 0. After 15 steps q_o=15, overflow_o=0. After step 16, q_o=0 and overflow_o=1. After step 17, q_o=1 and overflow_o=0.
- Down wrap: WIDTH=4, en_i=1, down_i=1 from 0 → q_o=15 and overflow_o=1 after one step. Next step gives q_o=14, overflow_o=0. Toggle down_i mid-run and check ±1 per enabled cycle.
- Load priority: q_o=7, assert load_i with en_i=1 and d_i=12 → q_o=12 (not 8), overflow_o=0. Next cycle en_i only → q_o=13. Drop en_i for 3 cycles → q_o holds 13.
- Sticky overflow: STICKY_OVERFLOW=1, WIDTH=4, load 14, count up 3 steps → q_o=1 and overflow_o=1. It stays 1 through 5 further steps and idle cycles. load_i with d_i=0 → overflow_o=0.
- Freeze pattern: WIDTH=32, count up to 639, then assert load_i with d_i=640 and en_i=0 for 4 cycles → q_o=640 steady. Then clear_i → q_o=0, overflow_o=0.

Source files
------------

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-2^WIDTH up/down counter with clear, parallel load, enable
// and a wrap flag that is either per-step or sticky until clear/load.
module sync_updown_counter #(
  parameter int unsigned WIDTH           = 4,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] OneVal = WIDTH'(1);
  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             wrap;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    q_d   = q_q;
    ovf_d = ovf_q;
    wrap  = 1'b0;
    if (clear_i) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      q_d   = d_i;
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (down_i) begin
        wrap = (q_q == '0);
        q_d  = q_q - OneVal;
      end else begin
        wrap = (q_q == MaxVal);
        q_d  = q_q + OneVal;
      end
      // Sticky mode only ever sets the flag on a step; clear/load drop it.
      if (STICKY_OVERFLOW) ovf_d = ovf_q | wrap;
      else                 ovf_d = wrap;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q_o        = q_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: three counter variants (4-bit plain, 4-bit sticky,
// 32-bit plain) share stimulus and are compared with an arithmetic model.
module tb_sync_updown_counter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear = 1'b0, en = 1'b0, load = 1'b0, down = 1'b0;
  logic [31:0] d = '0;
  logic [3:0]  d_n;
  logic [3:0]  q_a, q_s;
  logic [31:0] q_w;
  logic        f_a, f_s, f_w;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state per instance: 0 = plain 4-bit, 1 = sticky 4-bit, 2 = plain 32-bit
  longint unsigned m_q[3];
  bit              m_f[3];
  longint unsigned modv[3] = '{64'd16, 64'd16, 64'h1_0000_0000};
  bit              sticky[3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk_i = ~clk_i;
  assign d_n = d[3:0];

  sync_updown_counter #(.WIDTH(4), .STICKY_OVERFLOW(1'b0)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear), .en_i(en), .load_i(load),
    .down_i(down), .d_i(d_n), .q_o(q_a), .overflow_o(f_a));

  sync_updown_counter #(.WIDTH(4), .STICKY_OVERFLOW(1'b1)) u_sticky (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear), .en_i(en), .load_i(load),
    .down_i(down), .d_i(d_n), .q_o(q_s), .overflow_o(f_s));

  sync_updown_counter #(.WIDTH(32), .STICKY_OVERFLOW(1'b0)) u_wide (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear), .en_i(en), .load_i(load),
    .down_i(down), .d_i(d), .q_o(q_w), .overflow_o(f_w));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i] = 0;
      m_f[i] = 1'b0;
    end
  endtask

  // Applies the documented per-cycle rules with plain modular arithmetic.
  task automatic model_edge();
    bit wrapped;
    for (int i = 0; i < 3; i++) begin
      if (clear) begin
        m_q[i] = 0;
        m_f[i] = 1'b0;
      end else if (load) begin
        m_q[i] = longint'(d) % modv[i];
        m_f[i] = 1'b0;
      end else if (en) begin
        if (!down) begin
          wrapped = (m_q[i] + 1 >= modv[i]);
          m_q[i]  = (m_q[i] + 1) % modv[i];
        end else begin
          wrapped = (m_q[i] == 0);
          m_q[i]  = (m_q[i] + modv[i] - 1) % modv[i];
        end
        m_f[i] = sticky[i] ? (m_f[i] | wrapped) : wrapped;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/a_q"}, 64'(q_a), m_q[0]);
    check({tag, "/a_f"}, 64'(f_a), 64'(m_f[0]));
    check({tag, "/s_q"}, 64'(q_s), m_q[1]);
    check({tag, "/s_f"}, 64'(f_s), 64'(m_f[1]));
    check({tag, "/w_q"}, 64'(q_w), m_q[2]);
    check({tag, "/w_f"}, 64'(f_w), 64'(m_f[2]));
  endtask

  // Drive one cycle of inputs, let one rising edge pass, check on the falling edge.
  task automatic step(input logic c, input logic l, input logic e, input logic dn,
                      input logic [31:0] dv, input string tag);
    clear = c; load = l; en = e; down = dn; d = dv;
    @(posedge clk_i);
    if (rst_ni) model_edge();
    @(negedge clk_i);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(negedge clk_i);
    check_all("reset");
    rst_ni = 1'b1;

    // Count to 5, then reset asynchronously in the low clock phase
    repeat (5) step(0, 0, 1, 0, 32'h0, "cnt5");
    check("cnt5_val", 64'(q_a), 64'd5);
    #2 rst_ni = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    step(0, 0, 1, 0, 32'h0, "rst_held");
    rst_ni = 1'b1;

    // Clear dominates load and enable
    repeat (3) step(0, 0, 1, 0, 32'h0, "cnt3");
    step(1, 1, 1, 0, 32'd9, "clr_prio");
    check("clr_prio_q", 64'(q_a), 64'd0);

    // Up wrap from 0
    for (int i = 1; i <= 15; i++) step(0, 0, 1, 0, $urandom, "up");
    check("up15_q", 64'(q_a), 64'd15);
    check("up15_f", 64'(f_a), 64'd0);
    step(0, 0, 1, 0, $urandom, "up16");
    check("up16_q", 64'(q_a), 64'd0);
    check("up16_f", 64'(f_a), 64'd1);
    step(0, 0, 1, 0, $urandom, "up17");
    check("up17_q", 64'(q_a), 64'd1);
    check("up17_f", 64'(f_a), 64'd0);
    check("up17_sticky_f", 64'(f_s), 64'd1);

    // Down wrap from 0, then random direction changes
    step(1, 0, 0, 0, 32'h0, "clr");
    step(0, 0, 1, 1, $urandom, "dn1");
    check("dn1_q", 64'(q_a), 64'd15);
    check("dn1_f", 64'(f_a), 64'd1);
    step(0, 0, 1, 1, $urandom, "dn2");
    check("dn2_q", 64'(q_a), 64'd14);
    check("dn2_f", 64'(f_a), 64'd0);
    for (int i = 0; i < 24; i++) step(0, 0, 1, 1'($urandom), $urandom, "toggle");

    // Load beats enable, then count and hold
    step(0, 1, 0, 0, 32'd7, "ld7");
    step(0, 1, 1, 0, 32'd12, "ld12");
    check("ld12_q", 64'(q_a), 64'd12);
    check("ld12_f", 64'(f_a), 64'd0);
    step(0, 0, 1, 0, $urandom, "en13");
    check("en13_q", 64'(q_a), 64'd13);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1'($urandom), $urandom, "hold");
    check("hold_q", 64'(q_a), 64'd13);

    // Sticky overflow survives steps and idle cycles until a load
    step(0, 1, 0, 0, 32'd14, "ld14");
    repeat (3) step(0, 0, 1, 0, $urandom, "st_up");
    check("st_q", 64'(q_s), 64'd1);
    check("st_f", 64'(f_s), 64'd1);
    repeat (5) step(0, 0, 1, 1'($urandom), $urandom, "st_steps");
    repeat (3) step(0, 0, 0, 0, $urandom, "st_idle");
    check("st_keep_f", 64'(f_s), 64'd1);
    step(0, 1, 0, 0, 32'd0, "st_ld0");
    check("st_ld0_f", 64'(f_s), 64'd0);

    // Load all-ones then step up: wraps on the next enabled cycle
    step(0, 1, 0, 0, 32'hFFFF_FFFF, "ld_max");
    step(0, 0, 1, 0, $urandom, "max_wrap");
    check("max_wrap_wf", 64'(f_w), 64'd1);

    // Freeze pattern on the 32-bit counter
    step(1, 0, 0, 0, 32'h0, "fz_clr");
    for (int i = 0; i < 639; i++) step(0, 0, 1, 0, $urandom, "fz_cnt");
    check("fz_639", 64'(q_w), 64'd639);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'd640, "fz_ld");
    check("fz_640", 64'(q_w), 64'd640);
    step(1, 0, 0, 0, $urandom, "fz_clr2");
    check("fz_clr_q", 64'(q_w), 64'd0);
    check("fz_clr_f", 64'(f_w), 64'd0);

    // Random mix of all controls
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
